// File: rtl/sdram_line_scheduler.sv
// rtl/sdram_line_scheduler.sv - VGA line-refill and user single-word call scheduler in front of the SDRAM controller
module sdram_line_scheduler #(
    parameter int ADDR_W      = 24,
    parameter int Y_W         = 10,
    parameter int LINE_SHIFT  = 9,
    parameter int NBUF        = 2,
    parameter int BUF_SHIFT   = 19,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [Y_W:0]      iTag,
    input  logic              iSwap,
    input  logic [1:0]        iCall,
    input  logic [ADDR_W-1:0] iAddr,
    input  logic [15:0]       iData,
    output logic [1:0]        oDone,
    output logic [2:0]        oCall,
    output logic [ADDR_W-1:0] oAddr,
    output logic [ADDR_W-1:0] oAddrPage,
    output logic [15:0]       oWrData,
    input  logic [2:0]        iCtrlDone,
    output logic [1:0]        oDispBuf,
    output logic [7:0]        oMissCnt,
    output logic              oBusy
);

    generate
        if (BUF_SHIFT < Y_W + LINE_SHIFT) begin : gBadBufShift
            $error("sdram_line_scheduler: BUF_SHIFT must be >= Y_W + LINE_SHIFT");
        end
        if (NBUF < 1 || NBUF > 4) begin : gBadNbuf
            $error("sdram_line_scheduler: NBUF must be in 1..4");
        end
        if (SYNC_STAGES < 2) begin : gBadSync
            $error("sdram_line_scheduler: SYNC_STAGES must be >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, PAGE, USER, URLS} state_t;

    state_t            state;
    logic [Y_W:0]      syncQ [SYNC_STAGES];
    logic              tagHist;
    logic              pending;
    logic [Y_W-1:0]    pendY;
    logic              swapPend;

    logic              tagLevel;
    logic [Y_W-1:0]    tagY;
    logic              tagRise;
    logic              issuePage;
    logic              doSwap;
    logic [1:0]        nextBuf;
    logic [1:0]        issueBuf;
    logic [ADDR_W-1:0] pageAddr;
    logic [1:0]        userWin;

    assign tagLevel  = syncQ[SYNC_STAGES-1][Y_W];
    assign tagY      = syncQ[SYNC_STAGES-1][Y_W-1:0];
    assign tagRise   = tagLevel & ~tagHist;
    assign issuePage = (state == IDLE) && pending;

    // The swap is taken only at the top of a frame so the new buffer is shown whole.
    assign doSwap    = issuePage && (pendY == '0) && swapPend;
    assign nextBuf   = (oDispBuf == 2'(NBUF - 1)) ? 2'd0 : oDispBuf + 2'd1;
    assign issueBuf  = doSwap ? nextBuf : oDispBuf;
    assign pageAddr  = (ADDR_W'(issueBuf) << BUF_SHIFT) + (ADDR_W'(pendY) << LINE_SHIFT);
    assign userWin   = iCall[1] ? 2'b10 : 2'b01;
    assign oBusy     = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                syncQ[i] <= '0;
            end
        end else begin
            syncQ[0] <= iTag;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                syncQ[i] <= syncQ[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            tagHist   <= 1'b0;
            pending   <= 1'b0;
            pendY     <= '0;
            swapPend  <= 1'b0;
            oDispBuf  <= '0;
            oMissCnt  <= '0;
            oDone     <= '0;
            oCall     <= '0;
            oAddr     <= '0;
            oAddrPage <= '0;
            oWrData   <= '0;
        end else begin
            oDone   <= '0;
            tagHist <= tagLevel;

            // A rise in the issue cycle keeps the new line pending and is not a miss.
            if (tagRise) begin
                pendY   <= tagY;
                pending <= 1'b1;
                if (pending && !issuePage && oMissCnt != 8'hFF) begin
                    oMissCnt <= oMissCnt + 8'd1;
                end
            end else if (issuePage) begin
                pending <= 1'b0;
            end

            if (doSwap) begin
                oDispBuf <= nextBuf;
                swapPend <= iSwap;
            end else if (iSwap) begin
                swapPend <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (pending) begin
                        state     <= PAGE;
                        oCall     <= 3'b100;
                        oAddrPage <= pageAddr;
                    end else if (iCall != 2'b00) begin
                        state   <= USER;
                        oCall   <= {1'b0, userWin};
                        oAddr   <= iAddr;
                        oWrData <= iData;
                    end
                end
                PAGE: begin
                    if (iCtrlDone[2]) begin
                        oCall <= '0;
                        state <= IDLE;
                    end
                end
                USER: begin
                    if ((iCtrlDone[1:0] & oCall[1:0]) != 2'b00) begin
                        oDone <= oCall[1:0];
                        oCall <= '0;
                        state <= URLS;
                    end
                end
                URLS: begin
                    if (iCall == 2'b00) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_line_scheduler.sv
// tb/tb_sdram_line_scheduler.sv - randomized scoreboard bench for sdram_line_scheduler
module tb_sdram_line_scheduler;

    localparam int NBUF = 2;
    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] iTag = '0;
    logic        iSwap = 1'b0;
    logic [1:0]  iCall = '0;
    logic [23:0] iAddr = '0;
    logic [15:0] iData = '0;
    logic [2:0]  iCtrlDone = '0;
    logic [1:0]  oDone;
    logic [2:0]  oCall;
    logic [23:0] oAddr;
    logic [23:0] oAddrPage;
    logic [15:0] oWrData;
    logic [1:0]  oDispBuf;
    logic [7:0]  oMissCnt;
    logic        oBusy;

    sdram_line_scheduler dut (
        .clk(clk), .rst(rst), .iTag(iTag), .iSwap(iSwap), .iCall(iCall),
        .iAddr(iAddr), .iData(iData), .oDone(oDone), .oCall(oCall),
        .oAddr(oAddr), .oAddrPage(oAddrPage), .oWrData(oWrData),
        .iCtrlDone(iCtrlDone), .oDispBuf(oDispBuf), .oMissCnt(oMissCnt),
        .oBusy(oBusy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  call;
        logic [23:0] addr;
        logic [15:0] data;
        logic [1:0]  disp;
    } issue_t;

    issue_t     expIssue[$];
    logic [1:0] expDone[$];

    int vectors = 0;
    int miscompares = 0;
    int mDisp = 0;
    int mSwap = 0;
    int mMiss = 0;
    logic [1:0] lastBits;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        logic [2:0] prevCall;
        issue_t e;
        logic [1:0] d;
        prevCall = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prevCall = '0;
            end else begin
                if (oCall != 3'b000 && prevCall == 3'b000) begin
                    if (expIssue.size() == 0) begin
                        check("unexpected_issue", {29'b0, oCall}, 32'h0);
                    end else begin
                        e = expIssue.pop_front();
                        check("issue_call", {29'b0, oCall}, {29'b0, e.call});
                        check("issue_disp", {30'b0, oDispBuf}, {30'b0, e.disp});
                        if (e.call == 3'b100) begin
                            check("page_addr", {8'b0, oAddrPage}, {8'b0, e.addr});
                        end else begin
                            check("user_addr", {8'b0, oAddr}, {8'b0, e.addr});
                            check("user_data", {16'b0, oWrData}, {16'b0, e.data});
                        end
                    end
                end
                if (oDone != 2'b00) begin
                    if (expDone.size() == 0) begin
                        check("unexpected_done", {30'b0, oDone}, 32'h0);
                    end else begin
                        d = expDone.pop_front();
                        check("done_bits", {30'b0, oDone}, {30'b0, d});
                    end
                end
                prevCall = oCall;
            end
        end
    end

    task automatic pushPage(input logic [9:0] y);
        issue_t e;
        if (mSwap != 0 && y == 10'd0) begin
            mDisp = (mDisp + 1) % NBUF;
            mSwap = 0;
        end
        e.call = 3'b100;
        e.addr = 24'((mDisp * 524288 + int'(y) * 512) % 16777216);
        e.data = '0;
        e.disp = 2'(mDisp);
        expIssue.push_back(e);
    endtask

    task automatic waitCall();
        int n;
        n = 0;
        while (oCall == 3'b000 && n < 64) begin
            tick();
            n++;
        end
        check("call_seen", {31'b0, oCall != 3'b000}, 32'h1);
    endtask

    task automatic tagPulse(input logic [9:0] y);
        iTag = {1'b1, y};
        repeat (SYNC + 1) tick();
        iTag = {1'b0, y};
        repeat (SYNC + 1) tick();
    endtask

    task automatic swapPulse();
        iSwap = 1'b1;
        tick();
        iSwap = 1'b0;
        mSwap = 1;
    endtask

    task automatic servicePage();
        waitCall();
        repeat ($urandom_range(0, 2)) tick();
        iCtrlDone = 3'b100;
        tick();
        iCtrlDone = '0;
        check("page_call_drop", {29'b0, oCall}, 32'h0);
    endtask

    task automatic userStart(input logic [1:0] c, input logic [23:0] a, input logic [15:0] d);
        issue_t e;
        lastBits = c[1] ? 2'b10 : 2'b01;
        e.call = {1'b0, lastBits};
        e.addr = a;
        e.data = d;
        e.disp = 2'(mDisp);
        expIssue.push_back(e);
        iCall = c;
        iAddr = a;
        iData = d;
        waitCall();
    endtask

    task automatic userFinish(input bit wrong, input bit expectIdle);
        repeat ($urandom_range(0, 2)) tick();
        if (wrong) begin
            iCtrlDone = {1'b1, ~lastBits};
            tick();
            iCtrlDone = '0;
            tick();
            check("ignore_wrong_done", {29'b0, oCall}, {29'b0, 1'b0, lastBits});
        end
        expDone.push_back(lastBits);
        iCtrlDone = {1'b0, lastBits};
        tick();
        iCtrlDone = '0;
        check("user_call_drop", {29'b0, oCall}, 32'h0);
        repeat (3) tick();
        check("held_busy", {31'b0, oBusy}, 32'h1);
        iCall = 2'b00;
        tick();
        if (expectIdle) check("release_idle", {31'b0, oBusy}, 32'h0);
    endtask

    task automatic missRun(input int k, input bit wrong);
        logic [9:0] y;
        y = '0;
        userStart(2'($urandom_range(1, 3)), 24'($urandom), 16'($urandom));
        for (int i = 0; i < k; i++) begin
            y = ($urandom_range(0, 3) == 0) ? 10'd0 : 10'($urandom);
            tagPulse(y);
        end
        mMiss = (mMiss + k - 1 > 255) ? 255 : mMiss + k - 1;
        check("miss_cnt", {24'b0, oMissCnt}, 32'(mMiss));
        pushPage(y);
        userFinish(wrong, 1'b0);
        servicePage();
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int n;
        logic [9:0] y;
        repeat (3) tick();
        check("rst_call", {29'b0, oCall}, 32'h0);
        check("rst_done", {30'b0, oDone}, 32'h0);
        check("rst_page", {8'b0, oAddrPage}, 32'h0);
        check("rst_disp", {30'b0, oDispBuf}, 32'h0);
        check("rst_miss", {24'b0, oMissCnt}, 32'h0);
        check("rst_busy", {31'b0, oBusy}, 32'h0);
        rst = 1'b0;
        tick();

        // Single line refill: latency and address.
        pushPage(10'd5);
        iTag = {1'b1, 10'd5};
        n = 0;
        while (oCall == 3'b000 && n < 20) begin
            tick();
            n++;
        end
        check("tag_latency", 32'(n), 32'(SYNC + 2));
        check("t1_addr", {8'b0, oAddrPage}, 32'h000A00);
        iTag = {1'b0, 10'd5};
        repeat (SYNC + 1) tick();
        servicePage();

        userStart(2'b01, 24'h000123, 16'h0);
        userFinish(1'b0, 1'b1);

        swapPulse();
        pushPage(10'd0);
        tagPulse(10'd0);
        servicePage();
        check("swap_disp1", {30'b0, oDispBuf}, 32'h1);
        check("swap_addr", {8'b0, oAddrPage}, 32'h080000);
        swapPulse();
        pushPage(10'd0);
        tagPulse(10'd0);
        servicePage();
        check("swap_wrap", {30'b0, oDispBuf}, 32'h0);

        userStart(2'b10, 24'h00BEEF, 16'h1234);
        tagPulse(10'd7);
        tagPulse(10'd8);
        mMiss = mMiss + 1;
        check("t4_miss", {24'b0, oMissCnt}, 32'h1);
        pushPage(10'd8);
        userFinish(1'b0, 1'b0);
        servicePage();

        // Rise and user call reach IDLE together: page first, then write-wins user call.
        y = 10'($urandom);
        iTag = {1'b1, y};
        repeat (SYNC + 1) tick();
        pushPage(y);
        begin
            issue_t e;
            e.call = 3'b010;
            e.addr = 24'h00F00D;
            e.data = 16'hCAFE;
            e.disp = 2'(mDisp);
            expIssue.push_back(e);
        end
        iCall = 2'b11;
        iAddr = 24'h00F00D;
        iData = 16'hCAFE;
        waitCall();
        check("coincide_page_first", {29'b0, oCall}, 32'h4);
        iTag = {1'b0, y};
        servicePage();
        lastBits = 2'b10;
        waitCall();
        check("both_write_wins", {29'b0, oCall}, 32'h2);
        userFinish(1'b1, 1'b1);

        missRun(300, 1'b0);
        check("miss_saturated", {24'b0, oMissCnt}, 32'd255);

        // Reset in the middle of a page transaction.
        y = 10'($urandom);
        pushPage(y);
        tagPulse(y);
        waitCall();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_call", {29'b0, oCall}, 32'h0);
        check("rst_mid_page", {8'b0, oAddrPage}, 32'h0);
        check("rst_mid_busy", {31'b0, oBusy}, 32'h0);
        check("rst_mid_miss", {24'b0, oMissCnt}, 32'h0);
        check("rst_mid_done", {30'b0, oDone}, 32'h0);
        iTag = '0;
        repeat (3) tick();
        rst = 1'b0;
        mDisp = 0;
        mSwap = 0;
        mMiss = 0;
        tick();

        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 2))
                0: begin
                    if ($urandom_range(0, 2) == 0) swapPulse();
                    y = ($urandom_range(0, 3) == 0) ? 10'd0 : 10'($urandom);
                    pushPage(y);
                    tagPulse(y);
                    servicePage();
                end
                1: begin
                    userStart(2'($urandom_range(1, 3)), 24'($urandom), 16'($urandom));
                    userFinish(1'($urandom), 1'b1);
                end
                default: missRun($urandom_range(2, 4), 1'($urandom));
            endcase
            check("loop_disp", {30'b0, oDispBuf}, 32'(mDisp));
        end

        repeat (4) tick();
        check("issue_queue_empty", 32'(expIssue.size()), 32'h0);
        check("done_queue_empty", 32'(expDone.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
